// File: rtl/uart_rx_pkg.sv
// Shared oversampling constants and FSM encoding for the UART receive path.
// The baud generator imports the same OVERSAMPLE constant.
package uart_rx_pkg;

    localparam int         OVERSAMPLE        = 16;
    localparam logic [3:0] MID_TICK          = 4'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0] LAST_TICK         = 4'(OVERSAMPLE - 1);
    localparam int         DEFAULT_DATA_BITS = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } state_t;

endpackage

// File: rtl/uart_sync_2ff.sv
// Two-flop synchroniser for asynchronous inputs (rx now, CTS later).
// RESET_VAL sets the level both stages take during reset.
module uart_sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    logic meta;

    // NOTE: non-blocking assignments make meta and dout two real stages; blocking would collapse them.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RESET_VAL;
            dout <= RESET_VAL;
        end else begin
            meta <= din;
            dout <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 16x oversampled UART receiver: start/data/stop recovery with framing-error and break handling.
// Define UART_RX_PARITY_EN to add a parity bit between data and stop.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int DATA_BITS  = DEFAULT_DATA_BITS,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 baud_en_i,
    input  logic                 rx_i,
    output logic [DATA_BITS-1:0] data_o,
    output logic                 data_valid_o,
    output logic                 frame_err_o,
    output logic                 parity_err_o,
    output logic                 busy_o
);

    state_t               state, state_n;
    logic [3:0]           tick_cnt, tick_cnt_n;
    logic [2:0]           bit_cnt, bit_cnt_n;
    logic [DATA_BITS-1:0] shift, shift_n;
    logic [DATA_BITS-1:0] data, data_n;
    logic                 parity_bad, parity_bad_n;
    logic                 valid, valid_n;
    logic                 frame_err, frame_err_n;
    logic                 parity_err, parity_err_n;
    logic                 rx_s;
    logic                 last_bit;

    uart_sync_2ff #(.RESET_VAL(1'b1)) u_sync (
        .clk  (clk_i),
        .rst  (rst_i),
        .din  (rx_i),
        .dout (rx_s)
    );

    assign last_bit = (bit_cnt == 3'(DATA_BITS - 1));

    always_comb begin
        // NOTE: every next value gets a default first, so no path leaves a latch behind.
        state_n      = state;
        tick_cnt_n   = tick_cnt;
        bit_cnt_n    = bit_cnt;
        shift_n      = shift;
        data_n       = data;
        parity_bad_n = parity_bad;
        valid_n      = 1'b0;
        frame_err_n  = 1'b0;
        parity_err_n = 1'b0;

        case (state)
            ST_IDLE: begin
                if (!rx_s) begin
                    state_n    = ST_START;
                    tick_cnt_n = '0;
                end
            end
            ST_START: begin
                if (baud_en_i) begin
                    tick_cnt_n = tick_cnt + 4'd1;
                    // A start bit that is gone by mid-bit was only a glitch.
                    if (tick_cnt == MID_TICK) begin
                        tick_cnt_n   = '0;
                        bit_cnt_n    = '0;
                        parity_bad_n = 1'b0;
                        state_n      = rx_s ? ST_IDLE : ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (baud_en_i) begin
                    tick_cnt_n = tick_cnt + 4'd1;
                    if (tick_cnt == LAST_TICK) begin
                        shift_n   = {rx_s, shift[DATA_BITS-1:1]};
                        bit_cnt_n = bit_cnt + 3'd1;
                        if (last_bit) begin
`ifdef UART_RX_PARITY_EN
                            state_n = ST_PARITY;
`else
                            state_n = ST_STOP;
`endif
                        end
                    end
                end
            end
            ST_PARITY: begin
                if (baud_en_i) begin
                    tick_cnt_n = tick_cnt + 4'd1;
                    if (tick_cnt == LAST_TICK) begin
                        parity_bad_n = rx_s ^ (^shift) ^ PARITY_ODD;
                        state_n      = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                if (baud_en_i) begin
                    tick_cnt_n = tick_cnt + 4'd1;
                    if (tick_cnt == LAST_TICK) begin
`ifdef UART_RX_PARITY_EN
                        parity_err_n = parity_bad;
`endif
                        // Leaving mid stop bit lets a back-to-back start edge be caught.
                        if (rx_s) begin
                            if (!parity_bad) begin
                                data_n  = shift;
                                valid_n = 1'b1;
                            end
                            state_n = ST_IDLE;
                        end else begin
                            frame_err_n = 1'b1;
                            state_n     = ST_BREAK;
                        end
                    end
                end
            end
            ST_BREAK: begin
                if (rx_s) begin
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= ST_IDLE;
            tick_cnt   <= '0;
            bit_cnt    <= '0;
            shift      <= '0;
            data       <= '0;
            parity_bad <= 1'b0;
            valid      <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            state      <= state_n;
            tick_cnt   <= tick_cnt_n;
            bit_cnt    <= bit_cnt_n;
            shift      <= shift_n;
            data       <= data_n;
            parity_bad <= parity_bad_n;
            valid      <= valid_n;
            frame_err  <= frame_err_n;
            parity_err <= parity_err_n;
        end
    end

    assign data_o       = data;
    assign data_valid_o = valid;
    assign frame_err_o  = frame_err;
    assign parity_err_o = parity_err;
    assign busy_o       = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: table of whole frames plus hand-written glitch,
// break, back-to-back and mid-frame reset sequences. Follows UART_RX_PARITY_EN.
module tb_uart_rx;

    localparam int BAUD_DIV = 12;
    localparam int BIT_CLKS = 16 * BAUD_DIV;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    typedef struct packed {
        logic [7:0] data;
        logic       stop;
        logic       bad_par;
        logic       exp_valid;
        logic [7:0] exp_data;
        logic       exp_ferr;
        logic       exp_perr;
    } vec_t;

    logic       clk     = 1'b0;
    logic       rst     = 1'b1;
    logic       baud_en = 1'b0;
    logic       rx      = 1'b1;
    logic [7:0] data;
    logic       data_valid;
    logic       frame_err;
    logic       parity_err;
    logic       busy;

    int total = 0;
    int bad   = 0;

    int         valid_cnt = 0;
    int         ferr_cnt  = 0;
    int         perr_cnt  = 0;
    int         wide_cnt  = 0;
    int         drift_cnt = 0;
    logic [7:0] got_q[$];

    vec_t vecs[7];

    uart_rx #(.DATA_BITS(8), .PARITY_ODD(1'b0)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .baud_en_i    (baud_en),
        .rx_i         (rx),
        .data_o       (data),
        .data_valid_o (data_valid),
        .frame_err_o  (frame_err),
        .parity_err_o (parity_err),
        .busy_o       (busy)
    );

    initial forever #5 clk = ~clk;

    // One-cycle tick every BAUD_DIV clocks, changed just after the rising edge.
    initial begin
        forever begin
            repeat (BAUD_DIV - 1) @(posedge clk);
            #1 baud_en = 1'b1;
            @(posedge clk);
            #1 baud_en = 1'b0;
        end
    end

    // Strobe monitor: counts pulses, flags pulses wider than one cycle and data changes without valid.
    initial begin
        logic       prev_valid = 1'b0;
        logic       prev_ferr  = 1'b0;
        logic       prev_rst   = 1'b1;
        logic [7:0] prev_data  = 8'h00;
        forever begin
            @(negedge clk);
            if (!rst && !prev_rst) begin
                if (data_valid) begin
                    valid_cnt++;
                    got_q.push_back(data);
                end
                if (frame_err)  ferr_cnt++;
                if (parity_err) perr_cnt++;
                if ((data_valid && prev_valid) || (frame_err && prev_ferr)) wide_cnt++;
                if (data !== prev_data && !data_valid) drift_cnt++;
            end
            prev_valid = data_valid;
            prev_ferr  = frame_err;
            prev_rst   = rst;
            prev_data  = data;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bit_time();
        repeat (BIT_CLKS) step();
    endtask

    task automatic gap(input int bits);
        repeat (bits * BIT_CLKS) step();
    endtask

    // Drives one frame LSB first; a low stop bit is followed by 40 low ticks of break.
    task automatic send_frame(input logic [7:0] d, input logic stop, input logic bad_par);
        rx = 1'b0;
        bit_time();
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            bit_time();
        end
        if (PAR_EN) begin
            rx = (^d) ^ bad_par;
            bit_time();
        end
        rx = stop;
        bit_time();
        if (!stop) begin
            repeat (40 * BAUD_DIV) step();
            @(negedge clk);
            check("break_busy", 32'(busy), 32'd1);
        end
        rx = 1'b1;
    endtask

    initial begin
        int v0, f0, p0, q0, busy_ticks;
        bit released;

        vecs[0] = '{8'hA5, 1'b1, 1'b0, 1'b1,    8'hA5, 1'b0, 1'b0};
        vecs[1] = '{8'h81, 1'b1, 1'b0, 1'b1,    8'h81, 1'b0, 1'b0};
        vecs[2] = '{8'h07, 1'b1, 1'b0, 1'b1,    8'h07, 1'b0, 1'b0};
        vecs[3] = '{8'h07, 1'b1, 1'b1, ~PAR_EN, 8'h07, 1'b0, PAR_EN};
        vecs[4] = '{8'h5A, 1'b0, 1'b0, 1'b0,    8'h07, 1'b1, 1'b0};
        vecs[5] = '{8'hC3, 1'b1, 1'b0, 1'b1,    8'hC3, 1'b0, 1'b0};
        vecs[6] = '{8'h3C, 1'b1, 1'b1, ~PAR_EN, (PAR_EN ? 8'hC3 : 8'h3C), 1'b0, PAR_EN};

        // Reset values, sampled while reset is still held.
        repeat (3) step();
        @(negedge clk);
        check("rst_data",  32'(data),       32'h0);
        check("rst_valid", 32'(data_valid), 32'h0);
        check("rst_ferr",  32'(frame_err),  32'h0);
        check("rst_perr",  32'(parity_err), 32'h0);
        check("rst_busy",  32'(busy),       32'h0);
        step();
        rst = 1'b0;
        repeat (20) step();
        @(negedge clk);
        check("idle_busy", 32'(busy), 32'h0);

        // Start glitch: 4 ticks low, then back high; busy must span exactly 8 ticks.
        v0 = valid_cnt; f0 = ferr_cnt; p0 = perr_cnt;
        step();
        rx = 1'b0;
        busy_ticks = 0;
        released   = 1'b0;
        for (int i = 0; i < 40 * BAUD_DIV; i++) begin
            @(negedge clk);
            if (busy && baud_en) busy_ticks++;
            if (i == 4 * BAUD_DIV) rx = 1'b1;
            if (i > 4 * BAUD_DIV && !busy) begin
                released = 1'b1;
                break;
            end
        end
        check("glitch_released", 32'(released), 32'd1);
        check("glitch_ticks",    32'(busy_ticks), 32'd8);
        gap(1);
        check("glitch_no_valid", valid_cnt - v0, 0);
        check("glitch_no_ferr",  ferr_cnt - f0,  0);
        check("glitch_no_perr",  perr_cnt - p0,  0);

        // Framing error with a held break, then a normal frame.
        v0 = valid_cnt; f0 = ferr_cnt;
        send_frame(8'h3C, 1'b0, 1'b0);
        gap(2);
        @(negedge clk);
        check("brk_ferr",  ferr_cnt - f0,  1);
        check("brk_valid", valid_cnt - v0, 0);
        check("brk_data",  32'(data), 32'h00);
        check("brk_busy",  32'(busy), 32'h0);
        v0 = valid_cnt;
        send_frame(8'h55, 1'b1, 1'b0);
        gap(2);
        @(negedge clk);
        check("after_brk_valid", valid_cnt - v0, 1);
        check("after_brk_data",  32'(data), 32'h55);

        // Table of isolated frames.
        for (int n = 0; n < 7; n++) begin
            v0 = valid_cnt; f0 = ferr_cnt; p0 = perr_cnt;
            send_frame(vecs[n].data, vecs[n].stop, vecs[n].bad_par);
            gap(2);
            @(negedge clk);
            check($sformatf("vec%0d_valid", n), valid_cnt - v0, 32'(vecs[n].exp_valid));
            check($sformatf("vec%0d_data", n),  32'(data),      32'(vecs[n].exp_data));
            check($sformatf("vec%0d_ferr", n),  ferr_cnt - f0,  32'(vecs[n].exp_ferr));
            check($sformatf("vec%0d_perr", n),  perr_cnt - p0,  32'(vecs[n].exp_perr));
            check($sformatf("vec%0d_busy", n),  32'(busy),      32'h0);
        end

        // Back-to-back frames with no idle gap.
        q0 = got_q.size(); f0 = ferr_cnt; p0 = perr_cnt;
        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0);
        gap(2);
        @(negedge clk);
        check("b2b_count", got_q.size() - q0, 2);
        if (got_q.size() - q0 == 2) begin
            check("b2b_first",  32'(got_q[q0]),     32'h00);
            check("b2b_second", 32'(got_q[q0 + 1]), 32'hFF);
        end
        check("b2b_ferr", ferr_cnt - f0, 0);
        check("b2b_perr", perr_cnt - p0, 0);

        // Reset in the middle of data bit 3 of 0x81, then resend.
        v0 = valid_cnt;
        step();
        rx = 1'b0;
        bit_time();
        rx = 1'b1;
        bit_time();
        rx = 1'b0;
        bit_time();
        bit_time();
        repeat (BIT_CLKS / 2) step();
        @(negedge clk);
        check("mid_frame_busy", 32'(busy), 32'h1);
        step();
        rst = 1'b1;
        rx  = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_data",  32'(data),       32'h00);
        check("mid_rst_busy",  32'(busy),       32'h0);
        check("mid_rst_valid", 32'(data_valid), 32'h0);
        gap(2);
        check("mid_rst_no_strobe", valid_cnt - v0, 0);
        send_frame(8'h81, 1'b1, 1'b0);
        gap(2);
        @(negedge clk);
        check("resend_valid", valid_cnt - v0, 1);
        check("resend_data",  32'(data), 32'h81);

        check("strobe_width",  wide_cnt,  0);
        check("data_drift",    drift_cnt, 0);
        check("perr_total",    perr_cnt,  PAR_EN ? 2 : 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
